// File: rtl/uart_tx_arb_if.sv
// Two-requester UART transmit arbiter bus: request/data/ack handshake per
// requester plus the serial line and status outputs.
interface uart_tx_arb_if #(
  parameter int DBIT = 8
);
  logic            req0;
  logic            req1;
  logic [DBIT-1:0] data0;
  logic [DBIT-1:0] data1;
  logic            ack0;
  logic            ack1;
  logic            tx;
  logic            busy;
  logic            tx_done;
  logic            owner;

  // Requesters side
  modport master (
    output req0, req1, data0, data1,
    input  ack0, ack1, tx, busy, tx_done, owner
  );

  // Arbiter/transmitter side
  modport slave (
    input  req0, req1, data0, data1,
    output ack0, ack1, tx, busy, tx_done, owner
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbitrated UART transmitter. Two requesters share one serial
// line; a frame is start bit, DBIT data bits LSB first, then SB_TICK ticks of
// stop. Timing is paced by a 16x oversampling strobe (s_tick).
module uart_tx_arb #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          s_tick,
  uart_tx_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bit counter is wide enough both for DBIT data bits and for the number of
  // 16-tick groups in the stop period; in STOP, {n, s} acts as one counter so
  // stop lengths beyond 16 ticks work with the 4-bit tick counter.
  localparam int NMAX = (DBIT > (SB_TICK + 15) / 16) ? DBIT : (SB_TICK + 15) / 16;
  localparam int NW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam logic [NW+3:0] STOP_LAST = (NW+4)'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DBIT - 1);

  state_t          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            done_q, done_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            gnt1;
  logic [DBIT-1:0] b_sh;

  // State and registered outputs; reset idles the line and points the
  // round-robin at requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: arbitration in IDLE, tick-paced bit timing elsewhere.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done_d  = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;
    gnt1    = 1'b0;
    b_sh    = b_q >> 1;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // With both pending, serve the one not served last
          gnt1    = bus.req1 && (!bus.req0 || !last_q);
          b_d     = gnt1 ? bus.data1 : bus.data0;
          ack0_d  = !gnt1;
          ack1_d  = gnt1;
          owner_d = gnt1;
          last_d  = gnt1;
          s_d     = '0;
          n_d     = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            tx_d    = b_q[0];
            state_d = DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = b_sh;
            if (n_q == BIT_LAST) begin
              n_d     = '0;
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              n_d  = n_q + NW'(1);
              tx_d = b_sh[0];
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if ({n_q, s_q} == STOP_LAST) begin
            n_d     = '0;
            s_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            {n_d, s_d} = {n_q, s_q} + (NW+4)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.tx      = tx_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.tx_done = done_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: s_tick every 4 clocks (64 clocks per bit),
// frames decoded by mid-bit sampling and compared with hand-given bytes.
module tb_uart_tx_arb;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       tick_en = 1'b1;
  logic [1:0] div     = 2'd0;
  logic       s_tick;

  always #5 clock = ~clock;
  always @(posedge clock) div <= div + 2'd1;
  assign s_tick = tick_en && (div == 2'd3);

  uart_tx_arb_if #(.DBIT(8)) b1();
  uart_tx_arb_if #(.DBIT(8)) b2();

  uart_tx_arb #(.DBIT(8), .SB_TICK(16)) dut (
    .clock(clock), .reset(reset), .s_tick(s_tick), .bus(b1)
  );
  uart_tx_arb #(.DBIT(8), .SB_TICK(32)) dut2 (
    .clock(clock), .reset(reset), .s_tick(s_tick), .bus(b2)
  );

  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_ack  = 0;
  int   n_done = 0;
  logic ack_prev = 1'b0;
  logic ack_long = 1'b0;

  // Pulse counters and ack-width watch on dut
  always @(negedge clock) begin
    if (b1.ack0 || b1.ack1) n_ack <= n_ack + 1;
    if (b1.tx_done) n_done <= n_done + 1;
    if ((b1.ack0 || b1.ack1) && ack_prev) ack_long <= 1'b1;
    ack_prev <= b1.ack0 | b1.ack1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for an ack on dut; check which one and the owner
  task automatic wait_ack(input string tag, input logic [1:0] exp_ack);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(b1.ack0 || b1.ack1) && k < 3000);
    chk({tag, "_ack"}, {30'd0, b1.ack1, b1.ack0}, {30'd0, exp_ack});
    chk({tag, "_owner"}, {31'd0, b1.owner}, {31'd0, exp_ack[1]});
  endtask

  // Called on the negedge that shows the ack: tx fell on the preceding edge.
  // Samples 10 bits mid-bit; optionally stalls ticks after sampling bit fz.
  task automatic rx_frame(input string tag, input logic [7:0] exp, input int fz);
    logic [9:0] bits;
    logic       fz_tx;
    int         n;
    int         extra;
    extra = (fz >= 0) ? 1000 : 0;
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? 32 : 64) @(negedge clock);
      bits[i] = b1.tx;
      if (i == fz) begin
        tick_en = 1'b0;
        fz_tx   = b1.tx;
        repeat (1000) @(negedge clock);
        chk({tag, "_frz_tx"}, {31'd0, b1.tx}, {31'd0, fz_tx});
        chk({tag, "_frz_busy"}, {31'd0, b1.busy}, 32'd1);
        tick_en = 1'b1;
      end
    end
    chk({tag, "_start"}, {31'd0, bits[0]}, 32'd0);
    chk({tag, "_data"}, {24'd0, bits[8:1]}, {24'd0, exp});
    chk({tag, "_stop"}, {31'd0, bits[9]}, 32'd1);
    n = 608 + extra;
    do begin
      @(negedge clock);
      n++;
    end while (!b1.tx_done && n < 700 + extra);
    chk({tag, "_done_time"}, {31'd0, (n >= 637 + extra && n <= 640 + extra)}, 32'd1);
    chk({tag, "_done_tx"}, {31'd0, b1.tx}, 32'd1);
  endtask

  initial begin
    int d;
    int k;
    b1.req0 = 1'b0; b1.req1 = 1'b0; b1.data0 = '0; b1.data1 = '0;
    b2.req0 = 1'b0; b2.req1 = 1'b0; b2.data0 = '0; b2.data1 = '0;
    repeat (3) @(negedge clock);
    chk("rst_tx", {31'd0, b1.tx}, 32'd1);
    chk("rst_busy", {31'd0, b1.busy}, 32'd0);
    chk("rst_ack", {30'd0, b1.ack1, b1.ack0}, 32'd0);
    chk("rst_done", {31'd0, b1.tx_done}, 32'd0);
    chk("rst_owner", {31'd0, b1.owner}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("idle_tick_busy", {31'd0, b1.busy}, 32'd0);
    chk("idle_tick_tx", {31'd0, b1.tx}, 32'd1);

    // Single byte from requester 0
    b1.data0 = 8'h55; b1.req0 = 1'b1;
    wait_ack("t1", 2'b01);
    b1.req0 = 1'b0;
    rx_frame("t1", 8'h55, -1);
    @(negedge clock);
    chk("t1_done_cnt", n_done, 32'd1);

    // Contention from reset: req0 first, then req1, nothing after
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    b1.data0 = 8'hA0; b1.data1 = 8'h0F; b1.req0 = 1'b1; b1.req1 = 1'b1;
    wait_ack("t2a", 2'b01);
    b1.req0 = 1'b0;
    rx_frame("t2a", 8'hA0, -1);
    wait_ack("t2b", 2'b10);
    b1.req1 = 1'b0;
    rx_frame("t2b", 8'h0F, -1);
    repeat (300) @(negedge clock);
    chk("t2_ack_cnt", n_ack, 32'd3);
    chk("t2_idle", {31'd0, b1.busy}, 32'd0);

    // Round-robin with req1 held continuously
    b1.data1 = 8'h11; b1.req1 = 1'b1;
    wait_ack("t3a", 2'b10);
    b1.data1 = 8'h33;
    b1.data0 = 8'h22; b1.req0 = 1'b1;
    rx_frame("t3a", 8'h11, -1);
    wait_ack("t3b", 2'b01);
    b1.req0 = 1'b0;
    rx_frame("t3b", 8'h22, -1);
    wait_ack("t3c", 2'b10);
    b1.req1 = 1'b0;
    rx_frame("t3c", 8'h33, -1);

    // Reset during data bit 3 (0x34 has bit3 = 0), then a clean frame
    b1.data0 = 8'h34; b1.req0 = 1'b1;
    wait_ack("t4", 2'b01);
    b1.req0 = 1'b0;
    repeat (32 + 64 * 4) @(negedge clock);
    chk("t4_pre_tx", {31'd0, b1.tx}, 32'd0);
    chk("t4_pre_busy", {31'd0, b1.busy}, 32'd1);
    d = n_done;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t4_abort_tx", {31'd0, b1.tx}, 32'd1);
    chk("t4_abort_busy", {31'd0, b1.busy}, 32'd0);
    chk("t4_abort_ack", {30'd0, b1.ack1, b1.ack0}, 32'd0);
    repeat (200) @(negedge clock);
    chk("t4_no_done", n_done, d);
    b1.data0 = 8'h96; b1.req0 = 1'b1;
    wait_ack("t4b", 2'b01);
    b1.req0 = 1'b0;
    rx_frame("t4b", 8'h96, -1);

    // Tick stall for 1000 clocks mid-data
    b1.data0 = 8'hC5; b1.req0 = 1'b1;
    wait_ack("t5", 2'b01);
    b1.req0 = 1'b0;
    rx_frame("t5", 8'hC5, 3);

    // Two stop bits on dut2: tx_done 9*64 + 128 clocks after grant
    b2.data0 = 8'hFF; b2.req0 = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!b2.ack0 && k < 3000);
    chk("t6_ack", {31'd0, b2.ack0}, 32'd1);
    chk("t6_owner", {31'd0, b2.owner}, 32'd0);
    b2.req0 = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 650) chk("t6_stop_tx", {31'd0, b2.tx}, 32'd1);
      if (k == 650) chk("t6_stop_busy", {31'd0, b2.busy}, 32'd1);
    end while (!b2.tx_done && k < 900);
    chk("t6_done_time", {31'd0, (k >= 701 && k <= 704)}, 32'd1);

    chk("ack_width", {31'd0, ack_long}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning stop-bit length in s_tick periods (16 = 1 stop bit, 32 = 2).
REQ-003 Port clock  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port s_tick  input  1  single-cycle 16x-oversampling strobe from the baud-rate generator.
REQ-006 Port req0 / req1  input  1 each  requester N has a byte pending; level, held until ackN.
REQ-007 Port data0 / data1  input  DBIT each  byte from requester N; stable while reqN high.
REQ-008 Port ack0 / ack1  output  1 each  one-cycle pulse: byte from requester N captured.
REQ-009 Port tx  output  1  serial line, idle high.
REQ-010 Port busy  output  1  high whenever state is not IDLE.
REQ-011 Port tx_done  output  1  one-cycle pulse at end of stop bit.
REQ-012 Port owner  output  1  index of the requester currently or last served.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP; all outputs registered.
REQ-014 In IDLE with req0 or req1 high, the next edge SHALL capture the granted data into a shift register, pulse the matching ack for exactly one cycle, set owner, clear tick and bit counters, drive tx=0 and enter START.
REQ-015 Arbitration SHALL be round-robin: both requesting -> grant the one not served last; one requesting -> grant it regardless of pointer.
REQ-016 The last-served pointer SHALL update only on grant; its reset value SHALL be 1 so req0 wins the first contention.
REQ-017 The tick counter (4 bits) SHALL increment only on cycles with s_tick=1; no state advance occurs without s_tick.
REQ-018 START SHALL hold tx=0 until the 16th s_tick after entry, then enter DATA with tick counter 0.
REQ-019 DATA SHALL send DBIT bits LSB first, each for exactly 16 s_tick periods; the shift register shifts right and the bit counter increments at each bit end.
REQ-020 After bit DBIT-1 completes, the FSM SHALL enter STOP with tx=1.
REQ-021 STOP SHALL hold tx=1 for SB_TICK s_tick periods, then return to IDLE with tx_done pulsed one cycle on the same edge.
REQ-022 Requests arriving while busy SHALL be ignored until IDLE; a request still high in IDLE is a new byte.
REQ-023 Back-to-back: a grant SHALL occur on the first edge after IDLE is entered, giving no more than one clock of idle line between frames.
REQ-024 reqN dropping mid-frame SHALL not affect the frame in progress.
REQ-025 s_tick high while in IDLE SHALL have no effect.

Reset
REQ-026 On reset: state IDLE, tx=1, busy=0, ack0=ack1=0, tx_done=0, owner=0, pointer=1, counters and shift register 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame on the next edge with tx=1, no tx_done and no ack.

Verification (s_tick driven every 4 clocks, so one bit = 64 clocks)
REQ-028 req0=1, data0=8'h55 -> ack0 pulse one cycle after; tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each about 64 clocks; tx_done once; owner=0.
REQ-029 req0 and req1 raised together from reset, data0=8'hA0, data1=8'h0F, both held -> frames in order 8'hA0 then 8'h0F; ack0 then ack1; no third frame after both drop.
REQ-030 req1 held continuously with a new byte after each ack, req0 raised during frame 1 -> frame 2 is req0's byte (round-robin), frame 3 is req1's.
REQ-031 Reset pulsed during DATA bit 3 -> tx=1 and busy=0 next cycle; no tx_done; a subsequent req0 gives a complete correct frame.
REQ-032 SB_TICK=32, byte 8'hFF -> stop bit lasts 128 clocks, then tx_done.
REQ-033 s_tick held 0 for 1000 clocks mid-DATA -> tx and counters frozen; frame resumes correctly when ticks restart.
